// File: rtl/operand_fetch_wb_pkg.sv
`default_nettype none
// ============================================================================
// operand_fetch_wb_pkg
// Shared sizing constants for the register bank and its initiator-side
// operand fetch / writeback block.
// Revision: 1.0 - initial release
// ============================================================================
package operand_fetch_wb_pkg;

  localparam int AW    = 5;        // register index width
  localparam int DW    = 32;       // data width
  localparam int NREGS = 1 << AW;  // architectural registers

  typedef logic [AW-1:0] reg_idx_t;
  typedef logic [DW-1:0] data_t;

endpackage : operand_fetch_wb_pkg
`default_nettype wire

// File: rtl/operand_fetch_wb_rf_scoreboard.sv
`default_nettype none
// ============================================================================
// rf_scoreboard
// Per-register outstanding-write tracker for the register bank.
//   clk_i          clock, rising edge
//   rst_ni         asynchronous active-low reset
//   set_i          an issued instruction claims register set_idx_i
//   set_idx_i      register being claimed
//   wb_valid_i     writeback result present this cycle
//   wb_rd_i        writeback destination
//   busy_mask_o    bit i set = write to register i outstanding
//   pending_cnt_o  number of set bits in busy_mask_o (up/down counter)
//   wb_err_o       sticky: writeback seen for a register that was not busy
// Revision: 1.0 - initial release
// ============================================================================
module rf_scoreboard
  import operand_fetch_wb_pkg::*;
(
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          set_i,
  input  logic [AW-1:0] set_idx_i,
  input  logic          wb_valid_i,
  input  logic [AW-1:0] wb_rd_i,
  output logic [NREGS-1:0] busy_mask_o,
  output logic [AW:0]   pending_cnt_o,
  output logic          wb_err_o
);

  localparam logic [AW:0] CNT_ONE = (AW+1)'(1);

  logic [NREGS-1:0] busy_q, busy_d;
  logic [AW:0]      cnt_q, cnt_d;
  logic             err_q, err_d;
  logic             clr;

  // A writeback only retires a register that is actually outstanding.
  assign clr = wb_valid_i & busy_q[wb_rd_i];

  always_comb begin
    busy_d = busy_q;
    // Clear first, then set, so a same-register set/clear leaves the new owner busy.
    if (clr)   busy_d[wb_rd_i]   = 1'b0;
    if (set_i) busy_d[set_idx_i] = 1'b1;

    // Issue logic never sets an already-busy register unless it is being
    // cleared in the same cycle, so +1/-1 keeps the count equal to popcount.
    cnt_d = cnt_q;
    case ({set_i, clr})
      2'b10:   cnt_d = cnt_q + CNT_ONE;
      2'b01:   cnt_d = cnt_q - CNT_ONE;
      default: cnt_d = cnt_q;
    endcase

    err_d = err_q | (wb_valid_i & ~busy_q[wb_rd_i]);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      busy_q <= '0;
      cnt_q  <= '0;
      err_q  <= 1'b0;
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
      err_q  <= err_d;
    end
  end

  assign busy_mask_o   = busy_q;
  assign pending_cnt_o = cnt_q;
  assign wb_err_o      = err_q;

endmodule : rf_scoreboard
`default_nettype wire

// File: rtl/operand_fetch_wb.sv
`default_nettype none
// ============================================================================
// operand_fetch_wb
// Initiator side of the register bank between decode and execute: drives the
// bank read ports, registers bypassed operands into a valid/ready stage, and
// passes writeback results through as bank write strobes. A per-register
// scoreboard stalls issue on RAW/WAW hazards.
//   clk_i / rst_ni             clock, asynchronous active-low reset
//   id_*                       decoded instruction handshake and fields
//   ex_*                       operand stage towards execute
//   wb_*                       writeback results (never stalled)
//   rf_sr1/rf_sr2/rf_rdData*   bank combinational read ports
//   rf_dr/rf_wrData/rf_write   bank write port
//   busy_mask/pending_cnt/wb_err  scoreboard status
// Revision: 1.0 - initial release
// ============================================================================
module operand_fetch_wb
  import operand_fetch_wb_pkg::*;
(
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             id_valid_i,
  output logic             id_ready_o,
  input  logic [AW-1:0]    id_rs1_i,
  input  logic [AW-1:0]    id_rs2_i,
  input  logic [AW-1:0]    id_rd_i,
  input  logic             id_wen_i,
  output logic             ex_valid_o,
  input  logic             ex_ready_i,
  output logic [DW-1:0]    ex_op1_o,
  output logic [DW-1:0]    ex_op2_o,
  output logic [AW-1:0]    ex_rd_o,
  output logic             ex_wen_o,
  input  logic             wb_valid_i,
  input  logic [AW-1:0]    wb_rd_i,
  input  logic [DW-1:0]    wb_data_i,
  output logic [AW-1:0]    rf_sr1_o,
  output logic [AW-1:0]    rf_sr2_o,
  input  logic [DW-1:0]    rf_rdData1_i,
  input  logic [DW-1:0]    rf_rdData2_i,
  output logic [AW-1:0]    rf_dr_o,
  output logic [DW-1:0]    rf_wrData_o,
  output logic             rf_write_o,
  output logic [NREGS-1:0] busy_mask_o,
  output logic [AW:0]      pending_cnt_o,
  output logic             wb_err_o
);

  logic             ex_valid_q;
  logic [DW-1:0]    ex_op1_q, ex_op2_q, ex_op1_d, ex_op2_d;
  logic [AW-1:0]    ex_rd_q;
  logic             ex_wen_q;
  logic [NREGS-1:0] busy;
  logic             byp1, byp2;
  logic             live1, live2, liverd, haz, issue;

  assign rf_sr1_o    = id_rs1_i;
  assign rf_sr2_o    = id_rs2_i;
  assign rf_dr_o     = wb_rd_i;
  assign rf_wrData_o = wb_data_i;
  assign rf_write_o  = wb_valid_i;

  assign byp1 = wb_valid_i & (wb_rd_i == id_rs1_i);
  assign byp2 = wb_valid_i & (wb_rd_i == id_rs2_i);

  // A busy register being written back this very cycle is no longer a hazard:
  // its value arrives through the bypass mux (sources) or it is re-owned (dest).
  assign live1  = busy[id_rs1_i] & ~byp1;
  assign live2  = busy[id_rs2_i] & ~byp2;
  assign liverd = id_wen_i & busy[id_rd_i] & ~(wb_valid_i & (wb_rd_i == id_rd_i));
  assign haz    = live1 | live2 | liverd;

  // Deliberately independent of id_valid_i.
  assign id_ready_o = (~ex_valid_q | ex_ready_i) & ~haz;
  assign issue      = id_valid_i & id_ready_o;

  assign ex_op1_d = byp1 ? wb_data_i : rf_rdData1_i;
  assign ex_op2_d = byp2 ? wb_data_i : rf_rdData2_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ex_valid_q <= 1'b0;
      ex_op1_q   <= '0;
      ex_op2_q   <= '0;
      ex_rd_q    <= '0;
      ex_wen_q   <= 1'b0;
    end else if (issue) begin
      ex_valid_q <= 1'b1;
      ex_op1_q   <= ex_op1_d;
      ex_op2_q   <= ex_op2_d;
      ex_rd_q    <= id_rd_i;
      ex_wen_q   <= id_wen_i;
    end else if (ex_ready_i) begin
      ex_valid_q <= 1'b0;
    end
  end

  assign ex_valid_o = ex_valid_q;
  assign ex_op1_o   = ex_op1_q;
  assign ex_op2_o   = ex_op2_q;
  assign ex_rd_o    = ex_rd_q;
  assign ex_wen_o   = ex_wen_q;

  rf_scoreboard u_scoreboard (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .set_i         (issue & id_wen_i),
    .set_idx_i     (id_rd_i),
    .wb_valid_i    (wb_valid_i),
    .wb_rd_i       (wb_rd_i),
    .busy_mask_o   (busy),
    .pending_cnt_o (pending_cnt_o),
    .wb_err_o      (wb_err_o)
  );

  assign busy_mask_o = busy;

endmodule : operand_fetch_wb
`default_nettype wire

// File: tb/tb_operand_fetch_wb.sv
`default_nettype none
// ============================================================================
// tb_operand_fetch_wb
// Self-checking bench for operand_fetch_wb: a stub register bank, a table of
// per-cycle stimulus rows with expected id_ready, a behavioural scoreboard
// model and a queue of expected operand-stage contents.
// Revision: 1.0 - initial release
// ============================================================================
module tb_operand_fetch_wb;
  import operand_fetch_wb_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst_ni;
  logic             id_valid, id_ready, id_wen;
  logic [AW-1:0]    id_rs1, id_rs2, id_rd;
  logic             ex_valid, ex_ready, ex_wen;
  logic [DW-1:0]    ex_op1, ex_op2;
  logic [AW-1:0]    ex_rd;
  logic             wb_valid;
  logic [AW-1:0]    wb_rd;
  logic [DW-1:0]    wb_data;
  logic [AW-1:0]    rf_sr1, rf_sr2, rf_dr;
  logic [DW-1:0]    rf_rdData1, rf_rdData2, rf_wrData;
  logic             rf_write;
  logic [NREGS-1:0] busy_mask;
  logic [AW:0]      pending_cnt;
  logic             wb_err;

  operand_fetch_wb dut (
    .clk_i(clk), .rst_ni(rst_ni),
    .id_valid_i(id_valid), .id_ready_o(id_ready),
    .id_rs1_i(id_rs1), .id_rs2_i(id_rs2), .id_rd_i(id_rd), .id_wen_i(id_wen),
    .ex_valid_o(ex_valid), .ex_ready_i(ex_ready),
    .ex_op1_o(ex_op1), .ex_op2_o(ex_op2), .ex_rd_o(ex_rd), .ex_wen_o(ex_wen),
    .wb_valid_i(wb_valid), .wb_rd_i(wb_rd), .wb_data_i(wb_data),
    .rf_sr1_o(rf_sr1), .rf_sr2_o(rf_sr2),
    .rf_rdData1_i(rf_rdData1), .rf_rdData2_i(rf_rdData2),
    .rf_dr_o(rf_dr), .rf_wrData_o(rf_wrData), .rf_write_o(rf_write),
    .busy_mask_o(busy_mask), .pending_cnt_o(pending_cnt), .wb_err_o(wb_err)
  );

  // Stub register bank with its own initial contents.
  logic [DW-1:0] bank [NREGS];
  logic          bank_loaded = 1'b0;
  assign rf_rdData1 = bank[rf_sr1];
  assign rf_rdData2 = bank[rf_sr2];
  always @(posedge clk) begin
    if (!bank_loaded) begin
      for (int i = 0; i < NREGS; i++) bank[i] <= DW'(32'h100 + i);
      bank[3] <= 32'h11;
      bank[4] <= 32'h22;
    end else if (rf_write) begin
      bank[rf_dr] <= rf_wrData;
    end
  end

  typedef struct {
    logic          iv;
    logic [AW-1:0] rs1, rs2, rd;
    logic          wen, exr, wbv;
    logic [AW-1:0] wbrd;
    logic [DW-1:0] wbd;
    logic          rdy;
  } vec_t;

  typedef struct {
    logic [DW-1:0] op1, op2;
    logic [AW-1:0] rd;
    logic          wen;
  } exp_t;

  exp_t             q[$];
  logic [NREGS-1:0] m_busy;
  int               m_cnt;
  logic             m_err, m_exv;
  int               nvec, nerr;

  function automatic vec_t mk(logic iv, int rs1, int rs2, int rd, logic wen, logic exr,
                              logic wbv, int wbrd, logic [DW-1:0] wbd, logic rdy);
    vec_t v;
    v.iv = iv; v.rs1 = AW'(rs1); v.rs2 = AW'(rs2); v.rd = AW'(rd); v.wen = wen;
    v.exr = exr; v.wbv = wbv; v.wbrd = AW'(wbrd); v.wbd = wbd; v.rdy = rdy;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock cycle: drive at posedge+1, check combinational outputs and the
  // operand stage mid-cycle, advance the model, check registered status after the edge.
  task automatic cycle(input vec_t v);
    logic haz, rdy, issue, xfer;
    exp_t e;
    id_valid = v.iv; id_rs1 = v.rs1; id_rs2 = v.rs2; id_rd = v.rd; id_wen = v.wen;
    ex_ready = v.exr; wb_valid = v.wbv; wb_rd = v.wbrd; wb_data = v.wbd;
    #4;
    haz = (m_busy[v.rs1] & ~(v.wbv && v.wbrd == v.rs1)) |
          (m_busy[v.rs2] & ~(v.wbv && v.wbrd == v.rs2)) |
          (v.wen & m_busy[v.rd] & ~(v.wbv && v.wbrd == v.rd));
    rdy = (~m_exv | v.exr) & ~haz;
    chk("id_ready_model", 64'(id_ready), 64'(rdy));
    chk("id_ready_table", 64'(id_ready), 64'(v.rdy));
    chk("rf_pass", {rf_write, rf_dr, rf_wrData, rf_sr1, rf_sr2},
        {v.wbv, v.wbrd, v.wbd, v.rs1, v.rs2});
    chk("ex_valid", 64'(ex_valid), 64'(m_exv));
    if (m_exv && q.size() > 0) begin
      chk("ex_op1", 64'(ex_op1), 64'(q[0].op1));
      chk("ex_op2", 64'(ex_op2), 64'(q[0].op2));
      chk("ex_rd_wen", {ex_rd, ex_wen}, {q[0].rd, q[0].wen});
    end
    issue = v.iv & rdy;
    xfer  = m_exv & v.exr;
    if (xfer && q.size() > 0) void'(q.pop_front());
    if (issue) begin
      e.op1 = (v.wbv && v.wbrd == v.rs1) ? v.wbd : bank[v.rs1];
      e.op2 = (v.wbv && v.wbrd == v.rs2) ? v.wbd : bank[v.rs2];
      e.rd  = v.rd;
      e.wen = v.wen;
      q.push_back(e);
    end
    m_exv = issue ? 1'b1 : (v.exr ? 1'b0 : m_exv);
    if (v.wbv) begin
      if (m_busy[v.wbrd]) begin m_busy[v.wbrd] = 1'b0; m_cnt--; end
      else m_err = 1'b1;
    end
    if (issue && v.wen) begin m_busy[v.rd] = 1'b1; m_cnt++; end
    @(posedge clk); #1;
    chk("busy_mask", 64'(busy_mask), 64'(m_busy));
    chk("pending_cnt", 64'(pending_cnt), 64'(m_cnt));
    chk("wb_err", 64'(wb_err), 64'(m_err));
  endtask

  vec_t vt[18];

  initial begin
    nvec = 0; nerr = 0;
    m_busy = '0; m_cnt = 0; m_err = 1'b0; m_exv = 1'b0;
    // iv rs1 rs2 rd wen exr wbv wbrd wbd rdy
    vt[0]  = mk(0, 0, 0, 0, 0, 1, 0, 0, 32'h0,  1);
    vt[1]  = mk(1, 3, 4, 5, 1, 1, 0, 0, 32'h0,  1);  // first issue
    vt[2]  = mk(1, 5, 4, 6, 1, 1, 0, 0, 32'h0,  0);  // RAW on r5
    vt[3]  = mk(1, 5, 4, 6, 1, 1, 1, 5, 32'hAB, 1);  // wb clears, bypass
    vt[4]  = mk(1, 1, 2, 8, 0, 0, 0, 0, 32'h0,  0);  // execute stalls
    vt[5]  = mk(1, 1, 2, 8, 0, 0, 0, 0, 32'h0,  0);
    vt[6]  = mk(1, 1, 2, 8, 0, 0, 0, 0, 32'h0,  0);
    vt[7]  = mk(1, 1, 2, 8, 0, 1, 0, 0, 32'h0,  1);  // back-to-back
    vt[8]  = mk(1, 0, 0, 7, 1, 1, 0, 0, 32'h0,  1);  // claim r7
    vt[9]  = mk(1, 1, 2, 7, 1, 1, 1, 7, 32'h77, 1);  // set+clear r7
    vt[10] = mk(0, 0, 0, 0, 0, 1, 1, 9, 32'h99, 1);  // wb to idle r9
    vt[11] = mk(0, 0, 0, 0, 0, 1, 1, 6, 32'h66, 1);  // retire r6
    vt[12] = mk(0, 0, 0, 0, 0, 1, 0, 0, 32'h0,  1);
    vt[13] = mk(1, 0, 0, 4, 1, 1, 0, 0, 32'h0,  1);
    vt[14] = mk(1, 0, 0, 5, 1, 1, 0, 0, 32'h0,  1);
    vt[15] = mk(1, 0, 0, 6, 1, 1, 0, 0, 32'h0,  1);
    vt[16] = mk(1, 1, 2, 0, 0, 1, 0, 0, 32'h0,  1);
    vt[17] = mk(0, 0, 0, 0, 0, 0, 0, 0, 32'h0,  0);  // hold the stage

    rst_ni = 1'b0;
    id_valid = 0; id_rs1 = '0; id_rs2 = '0; id_rd = '0; id_wen = 0;
    ex_ready = 1; wb_valid = 0; wb_rd = '0; wb_data = '0;
    repeat (2) @(posedge clk);
    #1;
    bank_loaded = 1'b1;
    chk("rst_state", {ex_valid, ex_op1, ex_rd, ex_wen, wb_err},
        {1'b0, 32'h0, 5'h0, 1'b0, 1'b0});
    chk("rst_busy", {busy_mask, 26'h0, pending_cnt}, 64'h0);
    rst_ni = 1'b1;

    for (int i = 0; i < 18; i++) cycle(vt[i]);

    // Asynchronous reset in the middle of a cycle with work outstanding.
    id_valid = 0; ex_ready = 0; wb_valid = 0;
    chk("pre_rst_busy", 64'(busy_mask), 64'h0000_00F0);
    chk("pre_rst_exv", 64'(ex_valid), 64'h1);
    #2 rst_ni = 1'b0;
    #1;
    chk("async_rst_exv", 64'(ex_valid), 64'h0);
    chk("async_rst_busy", {busy_mask, 26'h0, pending_cnt}, 64'h0);
    chk("async_rst_op", {ex_op1, ex_op2}, 64'h0);
    @(posedge clk); #1;
    rst_ni = 1'b1;
    m_busy = '0; m_cnt = 0; m_err = 1'b0; m_exv = 1'b0; q.delete();

    // Writeback to a register orphaned by the reset is flagged.
    cycle(mk(0, 0, 0, 0, 0, 1, 1, 4, 32'h44, 1));
    chk("post_rst_wb_err", 64'(wb_err), 64'h1);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule : tb_operand_fetch_wb
`default_nettype wire
